// File: rtl/lzrw1_item_unpacker.sv
// LZRW1 item unpacker: splits a raw compressed byte stream into literal/copy items for the decompressor.
// Optional build macro STATS_EN adds saturating literal/copy transfer counters.
module lzrw1_item_unpacker #(
  parameter int CW_BITS = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      data_out,
  output logic             control_word_out,
  output logic             data_out_valid,
  input  logic             dec_busy,
  output logic             done,
  output logic             error,
`ifdef STATS_EN
  output logic [CNT_W-1:0] lit_count,
  output logic [CNT_W-1:0] copy_count,
`endif
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_CTRL0  = 3'd0,
    S_CTRL1  = 3'd1,
    S_LIT    = 3'd2,
    S_CPY_HI = 3'd3,
    S_CPY_LO = 3'd4,
    S_EMIT   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(CW_BITS - 1);

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_run;
  logic [15:0] r_cw;
  logic [3:0]  r_idx;
  logic [15:0] r_data;
  logic        r_cwo;
  logic        r_last;
  logic        r_done;
  logic        r_error;
  logic        w_fire;
  logic        w_xfer;
  logic        w_next_bit;

  // Byte handshake: a byte moves on a rising edge with in_valid & in_ready.
  // Item handshake: an item moves on a rising edge with data_out_valid & !dec_busy.
  assign w_fire     = in_valid & in_ready;
  assign w_xfer     = data_out_valid & ~dec_busy;
  assign w_next_bit = r_cw[r_idx + 4'd1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_CTRL0;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    in_ready       = r_run && (r_state != S_EMIT);
    data_out_valid = (r_state == S_EMIT);
    case (r_state)
      S_CTRL0: if (w_fire) begin
        if (in_last)            w_state_nx = S_CTRL0;
        else if (CW_BITS == 16) w_state_nx = S_CTRL1;
        else                    w_state_nx = in_byte[0] ? S_CPY_HI : S_LIT;
      end
      S_CTRL1: if (w_fire) begin
        if (in_last) w_state_nx = S_CTRL0;
        else         w_state_nx = r_cw[0] ? S_CPY_HI : S_LIT;
      end
      S_LIT:    if (w_fire) w_state_nx = S_EMIT;
      S_CPY_HI: if (w_fire) w_state_nx = in_last ? S_CTRL0 : S_CPY_LO;
      S_CPY_LO: if (w_fire) w_state_nx = S_EMIT;
      S_EMIT: if (w_xfer) begin
        if (r_last || (r_idx == LAST_IDX)) w_state_nx = S_CTRL0;
        else                               w_state_nx = w_next_bit ? S_CPY_HI : S_LIT;
      end
      default: w_state_nx = S_CTRL0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run   <= 1'b0;
      r_cw    <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_cwo   <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        S_CTRL0: if (w_fire) begin
          r_cw[7:0] <= in_byte;
          r_idx     <= '0;
          r_done    <= in_last;
        end
        S_CTRL1: if (w_fire) begin
          r_cw[15:8] <= in_byte;
          r_done     <= in_last;
        end
        S_LIT: if (w_fire) begin
          r_data <= {8'h00, in_byte};
          r_cwo  <= 1'b0;
          r_last <= in_last;
        end
        S_CPY_HI: if (w_fire) begin
          r_data[15:8] <= in_byte;
          // A stream ending mid-copy drops the half item and flags it permanently.
          if (in_last) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_CPY_LO: if (w_fire) begin
          r_data[7:0] <= in_byte;
          r_cwo       <= 1'b1;
          r_last      <= in_last;
        end
        S_EMIT: if (w_xfer) begin
          r_done <= r_last;
          r_idx  <= (r_last || (r_idx == LAST_IDX)) ? 4'd0 : r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign data_out         = r_data;
  assign control_word_out = r_cwo;
  assign done             = r_done;
  assign error            = r_error;
  assign o_dbg_state      = r_state;

`ifdef STATS_EN
  logic [CNT_W-1:0] r_lit_cnt;
  logic [CNT_W-1:0] r_copy_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lit_cnt  <= '0;
      r_copy_cnt <= '0;
    end else if (w_xfer) begin
      if (r_cwo && (r_copy_cnt != '1))      r_copy_cnt <= r_copy_cnt + 1'b1;
      else if (!r_cwo && (r_lit_cnt != '1)) r_lit_cnt  <= r_lit_cnt + 1'b1;
    end
  end

  assign lit_count  = r_lit_cnt;
  assign copy_count = r_copy_cnt;
`endif

endmodule

// File: tb/tb_lzrw1_item_unpacker.sv
// Bench for lzrw1_item_unpacker: 8-bit and 16-bit control-word instances share one driver and scoreboard.
module tb_lzrw1_item_unpacker;
  localparam int CNT_W = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] in_byte;
  logic       in_valid, in_last, dec_busy, sel;
  logic       v8, v16;
  assign v8  = in_valid & ~sel;
  assign v16 = in_valid & sel;

  logic        rdy8, cwo8, val8, done8, err8, rdy16, cwo16, val16, done16, err16;
  logic [15:0] dat8, dat16;
  logic [2:0]  st8, st16;
`ifdef STATS_EN
  logic [CNT_W-1:0] lit8, cpy8, lit16, cpy16;
`endif

  lzrw1_item_unpacker #(.CW_BITS(8), .CNT_W(CNT_W)) u8 (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(v8), .in_last(in_last),
    .in_ready(rdy8), .data_out(dat8), .control_word_out(cwo8), .data_out_valid(val8),
    .dec_busy(dec_busy), .done(done8), .error(err8),
`ifdef STATS_EN
    .lit_count(lit8), .copy_count(cpy8),
`endif
    .o_dbg_state(st8));

  lzrw1_item_unpacker #(.CW_BITS(16), .CNT_W(CNT_W)) u16 (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(v16), .in_last(in_last),
    .in_ready(rdy16), .data_out(dat16), .control_word_out(cwo16), .data_out_valid(val16),
    .dec_busy(dec_busy), .done(done16), .error(err16),
`ifdef STATS_EN
    .lit_count(lit16), .copy_count(cpy16),
`endif
    .o_dbg_state(st16));

  logic        m_ready, m_cwo, m_valid, m_done, m_err;
  logic [15:0] m_data;
  assign m_ready = sel ? rdy16 : rdy8;
  assign m_cwo   = sel ? cwo16 : cwo8;
  assign m_valid = sel ? val16 : val8;
  assign m_done  = sel ? done16 : done8;
  assign m_err   = sel ? err16 : err8;
  assign m_data  = sel ? dat16 : dat8;

  // scoreboard
  logic [16:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (m_done) done_cnt++;
      if (m_valid && !dec_busy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $error("FAIL unexpected_item observed=%0h expected=none", {m_cwo, m_data});
        end else begin
          chk("item", {15'd0, m_cwo, m_data}, {15'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic push_item(input logic cw, input logic [15:0] d);
    exp_q.push_back({cw, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    forever begin
      @(negedge clock);
      if (m_ready) break;
      t++;
      if (t > 200) begin
        n_vec++;
        n_fail++;
        $error("FAIL send_timeout observed=%0d expected=<200", t);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin @(posedge clock); #1; t++; end
    repeat (3) begin @(posedge clock); #1; end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int d0;
    logic [7:0] b;
    logic [15:0] held;
    in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; dec_busy = 1'b0; sel = 1'b0;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", rdy8, 0);
    chk("rst_data", dat8, 0);
    chk("rst_cwo", cwo8, 0);
    chk("rst_valid", val8, 0);
    chk("rst_done", done8, 0);
    chk("rst_error", err8, 0);
`ifdef STATS_EN
    chk("rst_lit", lit8, 0);
    chk("rst_copy", cpy8, 0);
`endif
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    // 8 literals, last on 'H'
    d0 = done_cnt;
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      b = 8'h41 + 8'(i);
      push_item(1'b0, {8'h00, b});
      send_byte(b, i == 7);
    end
    drain("t1_drain");
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_error", m_err, 0);

    // decompressor busy holds an item in EMIT
    d0 = done_cnt;
    dec_busy = 1'b1;
    send_byte(8'h00, 1'b0);
    push_item(1'b0, 16'h006b);
    send_byte(8'h6b, 1'b1);
    for (int t = 0; t < 50 && !m_valid; t++) @(negedge clock);
    chk("t3_valid_seen", m_valid, 1);
    held = m_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t3_hold_data", m_data, 16'h006b);
      chk("t3_hold_ready", m_ready, 0);
      chk("t3_hold_valid", m_valid, 1);
    end
    chk("t3_stable", m_data, held);
    @(posedge clock); #1 dec_busy = 1'b0;
    drain("t3_drain");
    chk("t3_done", done_cnt - d0, 1);

    // truncated copy after one literal
    d0 = done_cnt;
    send_byte(8'h02, 1'b0);
    push_item(1'b0, 16'h0061);
    send_byte(8'h61, 1'b0);
    send_byte(8'h56, 1'b1);
    drain("t4_drain");
    chk("t4_error", m_err, 1);
    chk("t4_done", done_cnt - d0, 1);
    push_item(1'b0, 16'h006d);
    send_byte(8'h00, 1'b0);
    send_byte(8'h6d, 1'b1);
    drain("t4_drain2");
    chk("t4_error_sticky", m_err, 1);

    // 16-bit control word: one copy, 15 literals, then a new control word
    sel = 1'b1;
    d0 = done_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    push_item(1'b1, 16'habcd);
    send_byte(8'hab, 1'b0);
    send_byte(8'hcd, 1'b0);
    for (int i = 0; i < 15; i++) begin
      b = (i == 0) ? 8'h7a : 8'($urandom_range(0, 255));
      push_item(1'b0, {8'h00, b});
      send_byte(b, 1'b0);
    end
    drain("t5_drain");
    chk("t5_no_done", done_cnt - d0, 0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    drain("t5_drain2");
    chk("t5_ctrl_done", done_cnt - d0, 1);
    chk("t5_error", m_err, 0);
    sel = 1'b0;

    // reset while waiting for the copy's second byte
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("t6_in_cpy_lo", st8, 3'd4);
    #2 reset = 1'b0;
    #1;
    chk("t6_ready", rdy8, 0);
    chk("t6_data", dat8, 0);
    chk("t6_cwo", cwo8, 0);
    chk("t6_valid", val8, 0);
    chk("t6_done", done8, 0);
    chk("t6_error", err8, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // copy then literal after reset
    d0 = done_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    push_item(1'b1, 16'h1234);
    send_byte(8'h34, 1'b0);
    push_item(1'b0, 16'h0078);
    send_byte(8'h78, 1'b1);
    drain("t2_drain");
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_error", m_err, 0);
`ifdef STATS_EN
    chk("t2_lit_count", lit8, 1);
    chk("t2_copy_count", cpy8, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
